cache_control: RTL and testbench
================================

# cache_control

Control unit for the LC-3b two-way set-associative, write-back, write-allocate L1 cache. It sits between the CPU memory port and the cache datapath that holds the tag, valid, dirty and LRU arrays, the 128-bit line arrays and the word-select logic. It sequences hits, dirty-victim writebacks and line fills against physical memory. It also drives every load and mux select in the datapath.

## Interface
Parameters:
- none. Geometry comes from `lc3b_ctypes`: 8 sets, 2 ways, 16-byte lines.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- mem_read  in  1  CPU read request; held until mem_resp.
- mem_write  in  1  CPU write request; held until mem_resp. Never asserted together with mem_read.
- mem_byte_enable  in  2  CPU write byte mask (lc3b_mem_wmask). Passed through to the datapath in HIT.
- hit  in  2  per-way tag-match-and-valid for the current set, from the datapath.
- dirty  in  2  per-way dirty bit of the current set.
- lru  in  1  LRU way of the current set (0 or 1).
- pmem_resp  in  1  physical memory done; one-cycle pulse.
- mem_resp  out  1  CPU request complete; one-cycle pulse.
- pmem_read  out  1  line fill request.
- pmem_write  out  1  line writeback request.
- way_sel  out  1  way addressed by loads and the output mux.
- load_data  out  1  write the line array of way_sel.
- load_tag  out  1  write tag and valid of way_sel (valid ← 1).
- set_dirty  out  1  dirty of way_sel ← 1.
- clr_dirty  out  1  dirty of way_sel ← 0.
- load_lru  out  1  LRU of the set ← ~way_sel.
- data_src  out  1  0 = merged CPU write data; 1 = pmem line.
- pmem_addr_src  out  1  0 = CPU address; 1 = {victim tag, set, 4'b0}.

## Operation
- States: IDLE, HIT, WRITEBACK, ALLOCATE.
- All outputs are combinational from state and inputs. Every output is 0 in reset and in IDLE.
- IDLE: on mem_read | mem_write, go to HIT.
- HIT, when hit != 0:
  - way_sel = hit[1].
  - mem_resp = 1; load_lru = 1.
  - On a write, also load_data = 1, data_src = 0, set_dirty = 1.
  - Next state is IDLE.
- HIT, when hit == 0 (miss):
  - Victim way = lru.
  - If dirty[lru], go to WRITEBACK; otherwise go to ALLOCATE.
- hit == 2'b11 is illegal. The controller treats it as a way-1 hit, and the `ifdef` assertion flags it.
- WRITEBACK:
  - way_sel = victim; pmem_write = 1; pmem_addr_src = 1.
  - Hold until pmem_resp, then assert clr_dirty for that cycle and go to ALLOCATE.
- ALLOCATE:
  - way_sel = victim; pmem_read = 1; pmem_addr_src = 0.
  - Hold until pmem_resp. That cycle: load_data = 1, data_src = 1, load_tag = 1, clr_dirty = 1.
  - Go to HIT, which re-evaluates and now hits.
- The victim way is registered on the HIT→WRITEBACK/ALLOCATE transition. LRU changes made elsewhere cannot redirect an in-flight miss.

## Timing
- Read or write hit: request seen in IDLE, mem_resp in the next cycle. Latency is 2 cycles.
- Clean miss: IDLE, HIT, ALLOCATE for N cycles, HIT. mem_resp comes 3 + N cycles after the request, where N is the pmem latency in cycles.
- Dirty miss adds the WRITEBACK dwell: M + 1 more cycles of WRITEBACK before ALLOCATE, M being the writeback latency.
- pmem_read and pmem_write stay high until and including the pmem_resp cycle, then drop.
- The request is sampled only in IDLE and HIT. Dropping it mid-miss does not abort WRITEBACK or ALLOCATE.
- Asynchronous reset mid-miss:
  - State returns to IDLE immediately; pmem_read and pmem_write drop in the same cycle.
  - A pmem_resp arriving after reset is ignored.
  - Performance counters clear.

## Configuration
- CACHE_PERF_CNT_EN defined:
  - Adds 16-bit saturating outputs hit_count, miss_count and wb_count.
  - They increment on, respectively, a HIT-with-hit cycle that is the first lookup of a request, the HIT→miss transition, and WRITEBACK completion.
  - All counters reset to 0.
  - An immediate assertion on hit == 2'b11 is also compiled in.
- Undefined: no counters, ports or assertion. The core FSM is identical.

## Structure
- Add to `lc3b_ctypes`:
  - enum `cache_state_t` {IDLE, HIT, WRITEBACK, ALLOCATE}.
  - `lc3b_cache_way` (1 bit).
  - `CACHE_WAYS = 2`.
  - `lc3b_perf_cnt` (16 bit).
- Counters go in sub-module `cache_perf_counters` inside the CACHE_PERF_CNT_EN guard. The FSM stays in one module.

## Test plan
- Reset: hold rst_n low, then mem_read = 1. All outputs stay 0; after release, HIT follows in one cycle.
- Read hit: hit = 2'b01, mem_read → mem_resp pulses once on cycle 2, way_sel = 0, load_lru = 1, no pmem activity.
- Write hit: hit = 2'b10, mem_write, byte_enable = 2'b01 → load_data, set_dirty, way_sel = 1, data_src = 0, mem_resp on cycle 2.
- Clean miss:
  - Stimulus: hit = 0, lru = 1, dirty = 0, pmem latency 5.
  - Expected: pmem_read high for 5 cycles; load_tag, load_data and data_src = 1 on the resp cycle.
  - Then with hit = 2'b10: mem_resp at cycle 8.
- Dirty miss:
  - Stimulus: lru = 0, dirty = 2'b01.
  - Expected: pmem_write with pmem_addr_src = 1 until resp; clr_dirty; then ALLOCATE on way 0 and mem_resp.
  - wb_count = 1 when CACHE_PERF_CNT_EN is defined.
- Reset mid-ALLOCATE: drop rst_n → pmem_read is 0 in the same cycle. A later stray pmem_resp causes no loads and no mem_resp.

Source files
------------

// File: rtl/cache_control_pkg.sv
// Shared cache types for the LC-3b two-way set-associative L1 cache.
// Geometry: 8 sets, 2 ways, 16-byte lines.
package lc3b_ctypes;

  localparam int CACHE_WAYS       = 2;
  localparam int CACHE_SETS       = 8;
  localparam int CACHE_LINE_BYTES = 16;

  typedef logic [1:0]  lc3b_mem_wmask;
  typedef logic        lc3b_cache_way;
  typedef logic [15:0] lc3b_perf_cnt;

  typedef enum logic [1:0] {
    IDLE,
    HIT,
    WRITEBACK,
    ALLOCATE
  } cache_state_t;

endpackage

// File: rtl/cache_control_perf_counters.sv
// Saturating hit/miss/writeback event counters for the L1 cache controller.
// Only compiled when CACHE_PERF_CNT_EN is defined.
`ifdef CACHE_PERF_CNT_EN
module cache_perf_counters
  import lc3b_ctypes::*;
(
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_inc_hit,
  input  logic         i_inc_miss,
  input  logic         i_inc_wb,
  output lc3b_perf_cnt o_hit_count,
  output lc3b_perf_cnt o_miss_count,
  output lc3b_perf_cnt o_wb_count
);

  lc3b_perf_cnt r_hit_count;
  lc3b_perf_cnt r_miss_count;
  lc3b_perf_cnt r_wb_count;

  // Each counter sticks at all-ones rather than wrapping back to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hit_count  <= '0;
      r_miss_count <= '0;
      r_wb_count   <= '0;
    end else begin
      if (i_inc_hit && (r_hit_count != '1))
        r_hit_count <= r_hit_count + 16'd1;
      if (i_inc_miss && (r_miss_count != '1))
        r_miss_count <= r_miss_count + 16'd1;
      if (i_inc_wb && (r_wb_count != '1))
        r_wb_count <= r_wb_count + 16'd1;
    end
  end

  assign o_hit_count  = r_hit_count;
  assign o_miss_count = r_miss_count;
  assign o_wb_count   = r_wb_count;

endmodule
`endif

// File: rtl/cache_control.sv
// Control FSM for the LC-3b write-back, write-allocate L1 cache.
// Define CACHE_PERF_CNT_EN to add hit/miss/writeback counters and the hit==2'b11 assertion.
module cache_control
  import lc3b_ctypes::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  lc3b_mem_wmask         mem_byte_enable,
  input  logic [CACHE_WAYS-1:0] hit,
  input  logic [CACHE_WAYS-1:0] dirty,
  input  lc3b_cache_way         lru,
  input  logic                  pmem_resp,
  output logic                  mem_resp,
  output logic                  pmem_read,
  output logic                  pmem_write,
  output lc3b_cache_way         way_sel,
  output logic                  load_data,
  output logic                  load_tag,
  output logic                  set_dirty,
  output logic                  clr_dirty,
  output logic                  load_lru,
  output logic                  data_src,
  output logic                  pmem_addr_src
`ifdef CACHE_PERF_CNT_EN
  ,
  output lc3b_perf_cnt          hit_count,
  output lc3b_perf_cnt          miss_count,
  output lc3b_perf_cnt          wb_count
`endif
);

  cache_state_t  r_state;
  lc3b_cache_way r_victim;
  logic          w_req;
  logic          w_any_hit;
  logic          w_unused_wmask;

  assign w_req     = mem_read | mem_write;
  assign w_any_hit = (hit != '0);

  // Byte lanes are applied by the datapath merge logic; the controller only cares that it is a write.
  assign w_unused_wmask = ^mem_byte_enable;

  // The victim is latched on the miss so later LRU updates cannot retarget an in-flight miss.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_victim <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_req)
            r_state <= HIT;
        end
        HIT: begin
          if (!w_req || w_any_hit) begin
            r_state <= IDLE;
          end else begin
            r_victim <= lru;
            r_state  <= dirty[lru] ? WRITEBACK : ALLOCATE;
          end
        end
        WRITEBACK: begin
          if (pmem_resp)
            r_state <= ALLOCATE;
        end
        ALLOCATE: begin
          if (pmem_resp)
            r_state <= HIT;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  always_comb begin
    mem_resp      = 1'b0;
    pmem_read     = 1'b0;
    pmem_write    = 1'b0;
    way_sel       = 1'b0;
    load_data     = 1'b0;
    load_tag      = 1'b0;
    set_dirty     = 1'b0;
    clr_dirty     = 1'b0;
    load_lru      = 1'b0;
    data_src      = 1'b0;
    pmem_addr_src = 1'b0;
    case (r_state)
      HIT: begin
        // An illegal 2'b11 lands on way 1 because way_sel simply follows hit[1].
        if (w_req && w_any_hit) begin
          way_sel  = hit[1];
          mem_resp = 1'b1;
          load_lru = 1'b1;
          if (mem_write) begin
            load_data = 1'b1;
            set_dirty = 1'b1;
          end
        end
      end
      WRITEBACK: begin
        way_sel       = r_victim;
        pmem_write    = 1'b1;
        pmem_addr_src = 1'b1;
        clr_dirty     = pmem_resp;
      end
      ALLOCATE: begin
        way_sel   = r_victim;
        pmem_read = 1'b1;
        if (pmem_resp) begin
          load_data = 1'b1;
          data_src  = 1'b1;
          load_tag  = 1'b1;
          clr_dirty = 1'b1;
        end
      end
      default: begin
      end
    endcase
  end

`ifdef CACHE_PERF_CNT_EN
  logic r_first_lookup;

  // Only the lookup straight out of IDLE counts as a hit; the re-lookup after a fill does not.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      r_first_lookup <= 1'b0;
    else if (r_state == IDLE)
      r_first_lookup <= w_req;
    else if (r_state == HIT)
      r_first_lookup <= 1'b0;
  end

  cache_perf_counters u_perf (
    .clk          (clk),
    .rst_n        (rst_n),
    .i_inc_hit    ((r_state == HIT) && w_req && w_any_hit && r_first_lookup),
    .i_inc_miss   ((r_state == HIT) && w_req && !w_any_hit),
    .i_inc_wb     ((r_state == WRITEBACK) && pmem_resp),
    .o_hit_count  (hit_count),
    .o_miss_count (miss_count),
    .o_wb_count   (wb_count)
  );

  always @(posedge clk) begin
    if (rst_n && (r_state == HIT) && w_req)
      assert (hit != 2'b11);
  end
`endif

endmodule

// File: tb/tb_cache_control.sv
// Directed self-checking bench for cache_control: reset, hits, clean/dirty misses, reset mid-fill.
// Counter checks are compiled in when CACHE_PERF_CNT_EN is defined.
module tb_cache_control;
  import lc3b_ctypes::*;

  logic                  clk;
  logic                  rst_n;
  logic                  mem_read;
  logic                  mem_write;
  lc3b_mem_wmask         mem_byte_enable;
  logic [CACHE_WAYS-1:0] hit;
  logic [CACHE_WAYS-1:0] dirty;
  lc3b_cache_way         lru;
  logic                  pmem_resp;
  logic                  mem_resp;
  logic                  pmem_read;
  logic                  pmem_write;
  lc3b_cache_way         way_sel;
  logic                  load_data;
  logic                  load_tag;
  logic                  set_dirty;
  logic                  clr_dirty;
  logic                  load_lru;
  logic                  data_src;
  logic                  pmem_addr_src;
`ifdef CACHE_PERF_CNT_EN
  lc3b_perf_cnt          hit_count;
  lc3b_perf_cnt          miss_count;
  lc3b_perf_cnt          wb_count;
`endif

  int checks = 0;
  int errors = 0;

  // Output vector order:
  // {mem_resp, pmem_read, pmem_write, way_sel, load_data, load_tag, set_dirty, clr_dirty, load_lru, data_src, pmem_addr_src}
  localparam logic [10:0] OUT_IDLE        = 11'b00000000000;
  localparam logic [10:0] OUT_RD_HIT_W0   = 11'b10000000100;
  localparam logic [10:0] OUT_RD_HIT_W1   = 11'b10010000100;
  localparam logic [10:0] OUT_WR_HIT_W0   = 11'b10001010100;
  localparam logic [10:0] OUT_WR_HIT_W1   = 11'b10011010100;
  localparam logic [10:0] OUT_ALLOC_W1    = 11'b01010000000;
  localparam logic [10:0] OUT_ALLOC_RSP_W1 = 11'b01011101010;
  localparam logic [10:0] OUT_ALLOC_W0    = 11'b01000000000;
  localparam logic [10:0] OUT_ALLOC_RSP_W0 = 11'b01001101010;
  localparam logic [10:0] OUT_WB_W0       = 11'b00100000001;
  localparam logic [10:0] OUT_WB_RSP_W0   = 11'b00100001001;

  cache_control dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .mem_read        (mem_read),
    .mem_write       (mem_write),
    .mem_byte_enable (mem_byte_enable),
    .hit             (hit),
    .dirty           (dirty),
    .lru             (lru),
    .pmem_resp       (pmem_resp),
    .mem_resp        (mem_resp),
    .pmem_read       (pmem_read),
    .pmem_write      (pmem_write),
    .way_sel         (way_sel),
    .load_data       (load_data),
    .load_tag        (load_tag),
    .set_dirty       (set_dirty),
    .clr_dirty       (clr_dirty),
    .load_lru        (load_lru),
    .data_src        (data_src),
    .pmem_addr_src   (pmem_addr_src)
`ifdef CACHE_PERF_CNT_EN
    ,
    .hit_count       (hit_count),
    .miss_count      (miss_count),
    .wb_count        (wb_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [10:0] outs();
    return {mem_resp, pmem_read, pmem_write, way_sel, load_data, load_tag,
            set_dirty, clr_dirty, load_lru, data_src, pmem_addr_src};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset held with a live request keeps everything quiet; HIT follows one edge after release.
  task automatic test_reset();
    rst_n = 1'b0;
    mem_read = 1'b1;
    hit = 2'b01;
    repeat (3) begin
      tick();
      checks++;
      if (outs() !== OUT_IDLE) begin
        errors++;
        $display("[TB] FAIL reset_outputs actual=%b required=%b", outs(), OUT_IDLE);
      end
    end
    rst_n = 1'b1;
    #1;
    checks++;
    if (outs() !== OUT_IDLE) begin
      errors++;
      $display("[TB] FAIL reset_release_idle actual=%b required=%b", outs(), OUT_IDLE);
    end
    tick();
    checks++;
    if (outs() !== OUT_RD_HIT_W0) begin
      errors++;
      $display("[TB] FAIL reset_then_hit actual=%b required=%b", outs(), OUT_RD_HIT_W0);
    end
    tick();
    mem_read = 1'b0;
    #1;
  endtask

  task automatic test_read_hit();
    hit = 2'b01;
    mem_read = 1'b1;
    #1;
    checks++;
    if (outs() !== OUT_IDLE) begin
      errors++;
      $display("[TB] FAIL read_hit_idle actual=%b required=%b", outs(), OUT_IDLE);
    end
    tick();
    checks++;
    if (outs() !== OUT_RD_HIT_W0) begin
      errors++;
      $display("[TB] FAIL read_hit_resp actual=%b required=%b", outs(), OUT_RD_HIT_W0);
    end
    tick();
    mem_read = 1'b0;
    #1;
    checks++;
    if (outs() !== OUT_IDLE) begin
      errors++;
      $display("[TB] FAIL read_hit_single_pulse actual=%b required=%b", outs(), OUT_IDLE);
    end
  endtask

  task automatic test_write_hit();
    hit = 2'b10;
    mem_write = 1'b1;
    mem_byte_enable = 2'b01;
    #1;
    tick();
    checks++;
    if (outs() !== OUT_WR_HIT_W1) begin
      errors++;
      $display("[TB] FAIL write_hit_resp actual=%b required=%b", outs(), OUT_WR_HIT_W1);
    end
    tick();
    mem_write = 1'b0;
    #1;
    checks++;
    if (outs() !== OUT_IDLE) begin
      errors++;
      $display("[TB] FAIL write_hit_single_pulse actual=%b required=%b", outs(), OUT_IDLE);
    end
  endtask

  // Request is cycle 1; HIT 2; ALLOCATE 3..7 with memory answering on the fifth; HIT 8.
  task automatic test_clean_miss();
    int cyc;
    int rd;
    int resp_cyc;
    bit filled;
    hit = 2'b00;
    lru = 1'b1;
    dirty = 2'b00;
    mem_read = 1'b1;
    #1;
    cyc = 1;
    rd = 0;
    resp_cyc = 0;
    filled = 1'b0;
    while (cyc < 30 && resp_cyc == 0) begin
      tick();
      cyc++;
      pmem_resp = 1'b0;
      if (filled)
        hit = 2'b10;
      #1;
      if (pmem_read) begin
        rd++;
        if (rd == 5) begin
          pmem_resp = 1'b1;
          #1;
          filled = 1'b1;
          checks++;
          if (outs() !== OUT_ALLOC_RSP_W1) begin
            errors++;
            $display("[TB] FAIL clean_alloc_resp actual=%b required=%b", outs(), OUT_ALLOC_RSP_W1);
          end
        end else begin
          checks++;
          if (outs() !== OUT_ALLOC_W1) begin
            errors++;
            $display("[TB] FAIL clean_alloc_hold actual=%b required=%b", outs(), OUT_ALLOC_W1);
          end
        end
      end else if (mem_resp) begin
        resp_cyc = cyc;
        checks++;
        if (outs() !== OUT_RD_HIT_W1) begin
          errors++;
          $display("[TB] FAIL clean_final_hit actual=%b required=%b", outs(), OUT_RD_HIT_W1);
        end
      end
    end
    checks++;
    if (rd !== 5) begin
      errors++;
      $display("[TB] FAIL clean_pmem_read_cycles actual=%0d required=%0d", rd, 5);
    end
    checks++;
    if (resp_cyc !== 8) begin
      errors++;
      $display("[TB] FAIL clean_resp_cycle actual=%0d required=%0d", resp_cyc, 8);
    end
    pmem_resp = 1'b0;
    tick();
    mem_read = 1'b0;
    #1;
    checks++;
    if (outs() !== OUT_IDLE) begin
      errors++;
      $display("[TB] FAIL clean_back_to_idle actual=%b required=%b", outs(), OUT_IDLE);
    end
  endtask

  // Writeback memory answers 3 cycles after pmem_write rises (4 WRITEBACK cycles), fill after 2.
  // Request cycle 1, HIT 2, WRITEBACK 3..6, ALLOCATE 7..8, HIT 9. LRU flips mid-miss and must be ignored.
  task automatic test_dirty_miss();
    int cyc;
    int wr;
    int rd;
    int resp_cyc;
    bit filled;
    hit = 2'b00;
    lru = 1'b0;
    dirty = 2'b01;
    mem_write = 1'b1;
    mem_byte_enable = 2'b11;
    #1;
    cyc = 1;
    wr = 0;
    rd = 0;
    resp_cyc = 0;
    filled = 1'b0;
    while (cyc < 40 && resp_cyc == 0) begin
      tick();
      cyc++;
      pmem_resp = 1'b0;
      if (filled)
        hit = 2'b01;
      #1;
      if (pmem_write) begin
        wr++;
        lru = 1'b1;
        if (wr == 4) begin
          pmem_resp = 1'b1;
          #1;
          checks++;
          if (outs() !== OUT_WB_RSP_W0) begin
            errors++;
            $display("[TB] FAIL dirty_wb_resp actual=%b required=%b", outs(), OUT_WB_RSP_W0);
          end
        end else begin
          checks++;
          if (outs() !== OUT_WB_W0) begin
            errors++;
            $display("[TB] FAIL dirty_wb_hold actual=%b required=%b", outs(), OUT_WB_W0);
          end
        end
      end else if (pmem_read) begin
        rd++;
        if (rd == 2) begin
          pmem_resp = 1'b1;
          #1;
          filled = 1'b1;
          checks++;
          if (outs() !== OUT_ALLOC_RSP_W0) begin
            errors++;
            $display("[TB] FAIL dirty_alloc_resp actual=%b required=%b", outs(), OUT_ALLOC_RSP_W0);
          end
        end else begin
          checks++;
          if (outs() !== OUT_ALLOC_W0) begin
            errors++;
            $display("[TB] FAIL dirty_alloc_hold actual=%b required=%b", outs(), OUT_ALLOC_W0);
          end
        end
      end else if (mem_resp) begin
        resp_cyc = cyc;
        checks++;
        if (outs() !== OUT_WR_HIT_W0) begin
          errors++;
          $display("[TB] FAIL dirty_final_hit actual=%b required=%b", outs(), OUT_WR_HIT_W0);
        end
      end
    end
    checks++;
    if (wr !== 4) begin
      errors++;
      $display("[TB] FAIL dirty_wb_cycles actual=%0d required=%0d", wr, 4);
    end
    checks++;
    if (resp_cyc !== 9) begin
      errors++;
      $display("[TB] FAIL dirty_resp_cycle actual=%0d required=%0d", resp_cyc, 9);
    end
    pmem_resp = 1'b0;
    tick();
    mem_write = 1'b0;
    lru = 1'b0;
    dirty = 2'b00;
    #1;
`ifdef CACHE_PERF_CNT_EN
    checks++;
    if (hit_count !== 16'd3) begin
      errors++;
      $display("[TB] FAIL perf_hit_count actual=%0d required=%0d", hit_count, 3);
    end
    checks++;
    if (miss_count !== 16'd2) begin
      errors++;
      $display("[TB] FAIL perf_miss_count actual=%0d required=%0d", miss_count, 2);
    end
    checks++;
    if (wb_count !== 16'd1) begin
      errors++;
      $display("[TB] FAIL perf_wb_count actual=%0d required=%0d", wb_count, 1);
    end
`endif
  endtask

  task automatic test_reset_mid_allocate();
    hit = 2'b00;
    lru = 1'b0;
    dirty = 2'b00;
    mem_read = 1'b1;
    #1;
    tick();
    tick();
    checks++;
    if (pmem_read !== 1'b1) begin
      errors++;
      $display("[TB] FAIL rst_alloc_entered actual=%b required=%b", pmem_read, 1'b1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (outs() !== OUT_IDLE) begin
      errors++;
      $display("[TB] FAIL rst_alloc_drop actual=%b required=%b", outs(), OUT_IDLE);
    end
    #2;
    rst_n = 1'b1;
    mem_read = 1'b0;
    tick();
    pmem_resp = 1'b1;
    #1;
    checks++;
    if (outs() !== OUT_IDLE) begin
      errors++;
      $display("[TB] FAIL stray_resp_ignored actual=%b required=%b", outs(), OUT_IDLE);
    end
    tick();
    pmem_resp = 1'b0;
    #1;
    checks++;
    if (outs() !== OUT_IDLE) begin
      errors++;
      $display("[TB] FAIL stray_resp_after actual=%b required=%b", outs(), OUT_IDLE);
    end
`ifdef CACHE_PERF_CNT_EN
    checks++;
    if ({hit_count, miss_count, wb_count} !== 48'd0) begin
      errors++;
      $display("[TB] FAIL perf_cleared actual=%0d/%0d/%0d required=0/0/0", hit_count, miss_count, wb_count);
    end
`endif
  endtask

  initial begin
    rst_n = 1'b0;
    mem_read = 1'b0;
    mem_write = 1'b0;
    mem_byte_enable = 2'b00;
    hit = 2'b00;
    dirty = 2'b00;
    lru = 1'b0;
    pmem_resp = 1'b0;
    test_reset();
    test_read_hit();
    test_write_hit();
    test_clean_miss();
    test_dirty_miss();
    test_reset_mid_allocate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
